// File: rtl/fpu_pkg.sv
// Shared definitions for the floating-point add/subtract unit.
//   exp_size_f / mant_size_f / bias_f : IEEE-754 field geometry from operand width
//   fpu_state_t                       : sequencer states of fpu_addsub
//   cmd_t                             : operation select (add / subtract)
package fpu_pkg;

  function automatic int exp_size_f(input int bitness);
    case (bitness)
      16:      return 5;
      64:      return 11;
      default: return 8;
    endcase
  endfunction

  function automatic int mant_size_f(input int bitness);
    case (bitness)
      16:      return 10;
      64:      return 52;
      default: return 23;
    endcase
  endfunction

  function automatic int bias_f(input int bitness);
    return (1 << (exp_size_f(bitness) - 1)) - 1;
  endfunction

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    ALIGN  = 3'd2,
    ADD    = 3'd3,
    NORM   = 3'd4,
    ROUND  = 3'd5,
    PACK   = 3'd6,
    OUTPUT = 3'd7
  } fpu_state_t;

  typedef enum logic {
    CMD_ADD = 1'b0,
    CMD_SUB = 1'b1
  } cmd_t;

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter.
//   in_i    : vector to scan, MSB first
//   count_o : number of zeros above the most significant one (WIDTH if all zero)
module fpu_lzc #(
  parameter int WIDTH = 27,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CW-1:0]    count_o
);

  logic found;

  always_comb begin
    count_o = CW'(WIDTH);
    found   = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found && in_i[WIDTH-1-i]) begin
        count_o = CW'(i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_addsub.sv
// Multi-cycle IEEE-754 adder/subtractor (round to nearest even, no subnormals).
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   input_rdy / input_ack  : operand handshake, ack only while idle
//   data_a, data_b,command : operands and operation (0 = A+B, 1 = A-B)
//   output_rdy / output_ack: result handshake, result held until taken
//   result                 : packed IEEE-754 result
module fpu_addsub
  import fpu_pkg::*;
#(
  parameter int bitness   = 32,
  parameter int exp_size  = exp_size_f(bitness),
  parameter int mant_size = mant_size_f(bitness)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               input_rdy,
  output logic               input_ack,
  input  logic [bitness-1:0] data_a,
  input  logic [bitness-1:0] data_b,
  input  logic               command,
  output logic               output_rdy,
  input  logic               output_ack,
  output logic [bitness-1:0] result
);

  localparam int E  = exp_size;
  localparam int M  = mant_size;
  localparam int W  = M + 4;              // hidden bit, mantissa, guard/round/sticky
  localparam int XE = E + 2;              // signed exponent with headroom
  localparam int CW = $clog2(W + 1);
  localparam logic [E-1:0]          EXP_MAX = '1;
  localparam logic signed [XE-1:0]  ZERO_X  = '0;
  localparam logic signed [XE-1:0]  ONE_X   = {{(XE-1){1'b0}}, 1'b1};
  localparam logic signed [XE-1:0]  TOP_X   = {2'b00, EXP_MAX};
  localparam logic [bitness-1:0]    QNAN    = {1'b0, EXP_MAX, 1'b1, {(M-1){1'b0}}};

  fpu_state_t state_q, state_d;

  logic [bitness-1:0] a_q, b_q, spec_q, result_q;
  cmd_t               cmd_q;
  logic               sa_q, sb_q, special_q, sign_q, zero_q;
  logic [E-1:0]       ea_q, eb_q, ex_q;
  logic [M:0]         ma_q, mb_q, rm_q;
  logic [W-1:0]       xa_q, xb_q, nm_q;
  logic [W:0]         sum_q;
  logic signed [XE-1:0] ne_q, re_q;

  // ---------------- sequencer ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (input_rdy && input_ack) state_d = UNPACK;
      UNPACK:  state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = PACK;
      PACK:    state_d = OUTPUT;
      OUTPUT:  if (output_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign input_ack  = (state_q == IDLE) && !reset;
  assign output_rdy = (state_q == OUTPUT) && !reset;
  assign result     = result_q;

  // ---------------- UNPACK ----------------
  logic [E-1:0]       fa_e, fb_e;
  logic [M-1:0]       fa_m, fb_m;
  logic               un_sa, un_sb, a_nan, b_nan, a_inf, b_inf, un_spec;
  logic [M:0]         un_ma, un_mb;
  logic [bitness-1:0] un_sval;

  assign fa_e  = a_q[M +: E];
  assign fb_e  = b_q[M +: E];
  assign fa_m  = a_q[M-1:0];
  assign fb_m  = b_q[M-1:0];
  assign un_sa = a_q[bitness-1];
  assign un_sb = b_q[bitness-1] ^ (cmd_q == CMD_SUB);
  assign a_nan = (fa_e == EXP_MAX) && (fa_m != '0);
  assign b_nan = (fb_e == EXP_MAX) && (fb_m != '0);
  assign a_inf = (fa_e == EXP_MAX) && (fa_m == '0);
  assign b_inf = (fb_e == EXP_MAX) && (fb_m == '0);
  assign un_ma = (fa_e == '0) ? '0 : {1'b1, fa_m};
  assign un_mb = (fb_e == '0) ? '0 : {1'b1, fb_m};

  always_comb begin
    un_spec = 1'b1;
    un_sval = QNAN;
    if (a_nan || b_nan || (a_inf && b_inf && (un_sa != un_sb))) un_sval = QNAN;
    else if (a_inf) un_sval = {un_sa, EXP_MAX, {M{1'b0}}};
    else if (b_inf) un_sval = {un_sb, EXP_MAX, {M{1'b0}}};
    else            un_spec = 1'b0;
  end

  // ---------------- ALIGN ----------------
  logic           a_big;
  logic [E-1:0]   al_diff;
  logic [W-1:0]   al_big, al_small, al_sh, al_lost;

  always_comb begin
    a_big    = (ea_q >= eb_q);
    al_diff  = a_big ? (ea_q - eb_q) : (eb_q - ea_q);
    al_big   = a_big ? {ma_q, 3'b000} : {mb_q, 3'b000};
    al_small = a_big ? {mb_q, 3'b000} : {ma_q, 3'b000};
    al_lost  = '0;
    if (int'(al_diff) > M + 3) begin
      al_sh = {{(W-1){1'b0}}, |al_small};
    end else begin
      al_sh    = al_small >> al_diff;
      al_lost  = al_small & ((W'(1) << al_diff) - W'(1));
      al_sh[0] = al_sh[0] | (|al_lost);
    end
  end

  // ---------------- ADD ----------------
  logic [W:0] ad_sum;
  logic       ad_sign;

  always_comb begin
    if (sa_q == sb_q) begin
      ad_sum  = {1'b0, xa_q} + {1'b0, xb_q};
      ad_sign = sa_q;
    end else if (xa_q >= xb_q) begin
      ad_sum  = {1'b0, xa_q - xb_q};
      ad_sign = sa_q;
    end else begin
      ad_sum  = {1'b0, xb_q - xa_q};
      ad_sign = sb_q;
    end
    // exact cancellation of opposite signs yields +0
    if ((ad_sum == '0) && (sa_q != sb_q)) ad_sign = 1'b0;
  end

  // ---------------- NORM ----------------
  logic [CW-1:0]        lz;
  logic [W-1:0]         no_m;
  logic signed [XE-1:0] no_e;

  fpu_lzc #(.WIDTH(W), .CW(CW)) u_lzc (
    .in_i    (sum_q[W-1:0]),
    .count_o (lz)
  );

  always_comb begin
    if (sum_q[W]) begin
      no_m    = sum_q[W:1];
      no_m[0] = sum_q[1] | sum_q[0];
      no_e    = $signed({2'b00, ex_q}) + ONE_X;
    end else begin
      no_m = sum_q[W-1:0] << lz;
      no_e = $signed({2'b00, ex_q}) - $signed({{(XE-CW){1'b0}}, lz});
    end
  end

  // ---------------- ROUND ----------------
  logic                 rd_up;
  logic [M+1:0]         rd_sum;
  logic [M:0]           rd_m;
  logic signed [XE-1:0] rd_e;

  always_comb begin
    rd_up  = nm_q[2] & (nm_q[1] | nm_q[0] | nm_q[3]);
    rd_sum = {1'b0, nm_q[W-1:3]} + {{(M+1){1'b0}}, rd_up};
    if (rd_sum[M+1]) begin
      rd_m = rd_sum[M+1:1];
      rd_e = ne_q + ONE_X;
    end else begin
      rd_m = rd_sum[M:0];
      rd_e = ne_q;
    end
  end

  // ---------------- PACK ----------------
  logic [bitness-1:0] pk;

  always_comb begin
    if (special_q)                     pk = spec_q;
    else if (zero_q || re_q <= ZERO_X) pk = {sign_q, {(bitness-1){1'b0}}};
    else if (re_q >= TOP_X)            pk = {sign_q, EXP_MAX, {M{1'b0}}};
    else                               pk = {sign_q, re_q[E-1:0], rm_q[M-1:0]};
  end

  // ---------------- registers ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (input_rdy) begin
          a_q   <= data_a;
          b_q   <= data_b;
          cmd_q <= cmd_t'(command);
        end
        UNPACK: begin
          sa_q      <= un_sa;
          sb_q      <= un_sb;
          ea_q      <= fa_e;
          eb_q      <= fb_e;
          ma_q      <= un_ma;
          mb_q      <= un_mb;
          special_q <= un_spec;
          spec_q    <= un_sval;
        end
        ALIGN: begin
          xa_q <= a_big ? al_big : al_sh;
          xb_q <= a_big ? al_sh : al_big;
          ex_q <= a_big ? ea_q : eb_q;
        end
        ADD: begin
          sum_q  <= ad_sum;
          sign_q <= ad_sign;
        end
        NORM: begin
          nm_q   <= no_m;
          ne_q   <= no_e;
          zero_q <= (sum_q == '0);
        end
        ROUND: begin
          rm_q <= rd_m;
          re_q <= rd_e;
        end
        PACK:    result_q <= pk;
        default: ;
      endcase
    end
  end

endmodule
